i8088_bus_master: RTL

//  Minimum-mode 8088 bus initiator: turns single-beat requests into T1-T4 bus cycles
//  (ALE, IOM, RD/WR, DEN/DTR, multiplexed AD, A[19:8]) with READY wait states.

---
 rtl/i8088_bus_master.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/i8088_bus_master.sv
// i8088_bus_master: minimum-mode 8088 bus initiator.
// Converts single-beat read/write requests into T1-T4 bus cycles with
// READY-driven wait states. All pin outputs are registered.
// Optional feature: define BUS_TIMEOUT_EN to abort a cycle after MAX_WAIT
// wait states with rsp_err=1; otherwise the master waits on READY forever.
module i8088_bus_master #(
  parameter int MAX_WAIT = 15
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_iom,
  input  logic [19:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  input  logic        READY,
  output logic        ALE,
  output logic        IOM,
  output logic        RD,
  output logic        WR,
  output logic        DEN,
  output logic        DTR,
  output logic [11:0] A,
  inout  wire  [7:0]  AD
);

  typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_T3, S_TW, S_T4} state_t;

  state_t      state, state_next;
  logic        accept;
  logic        lat_write, lat_iom;
  logic [19:0] lat_addr;
  logic [7:0]  lat_wdata;
  logic [7:0]  ad_out;
  logic        ad_oe;
  logic        timed_out;
  logic        timeout_hit;

  assign req_ready = (state == S_IDLE) && !RESET;
  assign accept    = req_valid && req_ready;
  assign AD        = ad_oe ? ad_out : 8'hzz;

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = ($clog2(MAX_WAIT + 1) > 4) ? $clog2(MAX_WAIT + 1) : 4;
  logic [CNT_W-1:0] wait_cnt;

  // Wait-state counter: cleared in T2, counts every TW cycle entered.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                  wait_cnt <= '0;
    else if (state == S_T2)     wait_cnt <= '0;
    else if (state_next == S_TW) wait_cnt <= wait_cnt + 1'b1;
  end

  assign timeout_hit = (state == S_TW) && !READY && (wait_cnt >= CNT_W'(MAX_WAIT));
`else
  logic unused_max_wait;
  assign unused_max_wait = (MAX_WAIT != 0);
  assign timeout_hit     = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic; T3 and TW both wait for READY (or a timeout abort).
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (accept) state_next = S_T1;
      S_T1:        state_next = S_T2;
      S_T2:        state_next = S_T3;
      S_T3, S_TW:  if (READY || timeout_hit) state_next = S_T4;
                   else                      state_next = S_TW;
      S_T4:        state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  // Request capture on accept; held for the whole bus cycle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      lat_write <= 1'b0;
      lat_iom   <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (accept) begin
      lat_write <= req_write;
      lat_iom   <= req_iom;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
    end
  end

  // Registered pin and response outputs, computed from the state being entered.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ALE       <= 1'b0;
      IOM       <= 1'b0;
      RD        <= 1'b1;
      WR        <= 1'b1;
      DEN       <= 1'b1;
      DTR       <= 1'b1;
      A         <= '0;
      ad_out    <= '0;
      ad_oe     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      timed_out <= 1'b0;
    end else begin
      rsp_valid <= (state == S_T4);
      rsp_err   <= (state == S_T4) && timed_out;
      if ((state == S_T3 || state == S_TW) && READY && !lat_write)
        rsp_rdata <= AD;
      if (state_next == S_T1)  timed_out <= 1'b0;
      else if (timeout_hit)    timed_out <= 1'b1;
      case (state_next)
        S_T1: begin
          ALE    <= 1'b1;
          A      <= req_addr[19:8];
          ad_out <= req_addr[7:0];
          ad_oe  <= 1'b1;
          IOM    <= req_iom;
          DTR    <= req_write;
          RD     <= 1'b1;
          WR     <= 1'b1;
          DEN    <= 1'b1;
        end
        S_T2, S_T3, S_TW: begin
          ALE    <= 1'b0;
          A      <= lat_addr[19:8];
          IOM    <= lat_iom;
          DTR    <= lat_write;
          RD     <= lat_write;
          WR     <= !lat_write;
          DEN    <= 1'b0;
          ad_out <= lat_wdata;
          ad_oe  <= lat_write;
        end
        S_T4: begin
          ALE    <= 1'b0;
          RD     <= 1'b1;
          WR     <= 1'b1;
          DEN    <= 1'b1;
          ad_out <= lat_wdata;
          ad_oe  <= lat_write;
        end
        default: begin
          ALE    <= 1'b0;
          A      <= '0;
          IOM    <= 1'b0;
          DTR    <= 1'b1;
          RD     <= 1'b1;
          WR     <= 1'b1;
          DEN    <= 1'b1;
          ad_oe  <= 1'b0;
        end
      endcase
    end
  end

endmodule
